// File: rtl/nyq_pkg.sv
// ---------------------------------------------------------------------------
// nyq_pkg
// Shared definitions for the NYQ sample buffer writer and reader.
//   NYQ_DEPTH / NYQ_DATA_W : buffer geometry, common to both sides
//   NYQ_PTR_W / NYQ_FILL_W : pointer width and occupancy counter width
//   nyq_rd_state_t         : read-side output-stage FSM state
//   nyq_ptr_t              : buffer pointer / address type
// ---------------------------------------------------------------------------
package nyq_pkg;

   localparam int NYQ_DEPTH  = 8;
   localparam int NYQ_DATA_W = 16;
   localparam int NYQ_PTR_W  = $clog2(NYQ_DEPTH);
   localparam int NYQ_FILL_W = NYQ_PTR_W + 1;

   typedef enum logic {
      S_EMPTY = 1'b0,   // output register holds nothing to deliver
      S_FULL  = 1'b1    // output register holds an unconsumed entry
   } nyq_rd_state_t;

   typedef logic [NYQ_PTR_W-1:0] nyq_ptr_t;

endpackage

// File: rtl/nyq_rd_ptr.sv
// ---------------------------------------------------------------------------
// nyq_rd_ptr
// Down-counting wrapping read pointer, the reader-side twin of the NYQ write
// counter. Resets to DEPTH-1 and steps DEPTH-1, ..., 1, 0, DEPTH-1, ...
// Ports:
//   i_clk  clock
//   i_rst  synchronous active-high reset (pointer -> DEPTH-1)
//   i_en   advance the pointer by one position on this edge
//   o_ptr  current pointer value
// ---------------------------------------------------------------------------
module nyq_rd_ptr #(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   output logic [PTR_W-1:0] o_ptr
);

   localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [PTR_W-1:0] r_ptr;

   // Explicit wrap keeps the sequence correct even if DEPTH is ever not a
   // power of two.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= PTR_TOP;
      end else if (i_en) begin
         if (r_ptr == '0) r_ptr <= PTR_TOP;
         else             r_ptr <= r_ptr - PTR_ONE;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/nyq_rd_ctrl.sv
// ---------------------------------------------------------------------------
// nyq_rd_ctrl
// Read-side controller for the NYQ sample buffer. Tracks occupancy from the
// writer strobe, walks the buffer in write order (7,6,...,0,7,...) and hands
// entries to the downstream consumer through a registered output stage.
// Ports:
//   Clk_CI     clock
//   Rst_RI     synchronous active-high reset, overrides everything
//   WrEn_SI    writer strobe, one entry committed per high edge
//   RdAddr_DO  buffer read address (the read pointer)
//   RdData_DI  buffer data at RdAddr_DO, combinational
//   Data_DO    output data register
//   Valid_SO   Data_DO holds an unconsumed entry
//   Ready_SI   downstream accepts Data_DO
//   Fill_DO    entries written but not yet loaded into Data_DO
//   Empty_SO   Fill_DO == 0
//   Full_SO    Fill_DO == DEPTH
//   Ovf_SO     overflow indication
// Build option: NYQ_RD_OVF_STICKY_EN
//   defined   : Ovf_SO sets on the first overflow, clears only on reset
//   undefined : Ovf_SO is a one-cycle registered pulse after each overflow
//
// Handshake: Data_DO is transferred on every rising edge where
// Valid_SO && Ready_SI. Once Valid_SO is high, Data_DO and Valid_SO stay
// stable until that transfer happens. Valid_SO never depends on Ready_SI
// combinationally; Ready_SI only decides whether the next entry is loaded.
// Valid_SO is the direct decode of the output-stage FSM state.
// ---------------------------------------------------------------------------
module nyq_rd_ctrl
   import nyq_pkg::*;
#(
   parameter int DATA_W = NYQ_DATA_W,
   parameter int DEPTH  = NYQ_DEPTH,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int FILL_W = PTR_W + 1
) (
   input  logic              Clk_CI,
   input  logic              Rst_RI,
   input  logic              WrEn_SI,
   output logic [PTR_W-1:0]  RdAddr_DO,
   input  logic [DATA_W-1:0] RdData_DI,
   output logic [DATA_W-1:0] Data_DO,
   output logic              Valid_SO,
   input  logic              Ready_SI,
   output logic [FILL_W-1:0] Fill_DO,
   output logic              Empty_SO,
   output logic              Full_SO,
   output logic              Ovf_SO
);

   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);
   localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

   nyq_rd_state_t     r_state;
   nyq_rd_state_t     w_state_next;
   logic [FILL_W-1:0] r_fill;
   logic [FILL_W-1:0] w_fill_next;
   logic [DATA_W-1:0] r_data;
   logic              r_ovf;
   logic              w_load;
   logic              w_ovf;
   logic [PTR_W-1:0]  w_rd_ptr;

   // A new entry moves into the output register when one is available and
   // the register is either empty or being drained on this same edge.
   assign w_load = (r_fill != '0) && ((r_state == S_EMPTY) || Ready_SI);

   // ---------------- read pointer ----------------
   nyq_rd_ptr #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_rd_ptr (
      .i_clk (Clk_CI),
      .i_rst (Rst_RI),
      .i_en  (w_load),
      .o_ptr (w_rd_ptr)
   );

   // ---------------- output-stage FSM: state register ----------------
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) r_state <= S_EMPTY;
      else        r_state <= w_state_next;
   end

   // ---------------- output-stage FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      if (w_load) begin
         w_state_next = S_FULL;
      end else if ((r_state == S_FULL) && Ready_SI) begin
         // consumed with nothing behind it
         w_state_next = S_EMPTY;
      end
   end

   // ---------------- output-stage FSM: outputs ----------------
   always_comb begin
      Valid_SO = 1'b0;
      if (r_state == S_FULL) Valid_SO = 1'b1;
   end

   // ---------------- output data register ----------------
   // Only a load changes Data_DO; draining to empty leaves the last value.
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI)      r_data <= '0;
      else if (w_load) r_data <= RdData_DI;
   end

   // ---------------- occupancy ----------------
   // A write into a full buffer without a simultaneous load overwrites an
   // unread entry: the count saturates and the event is flagged.
   always_comb begin
      w_fill_next = r_fill;
      w_ovf       = 1'b0;
      case ({WrEn_SI, w_load})
         2'b10: begin
            if (r_fill == FILL_MAX) w_ovf = 1'b1;
            else                    w_fill_next = r_fill + FILL_ONE;
         end
         2'b01:   w_fill_next = r_fill - FILL_ONE;
         default: w_fill_next = r_fill;
      endcase
   end

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) r_fill <= '0;
      else        r_fill <= w_fill_next;
   end

   // ---------------- overflow flag ----------------
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         r_ovf <= 1'b0;
      end else begin
`ifdef NYQ_RD_OVF_STICKY_EN
         if (w_ovf) r_ovf <= 1'b1;
`else
         r_ovf <= w_ovf;
`endif
      end
   end

   assign RdAddr_DO = w_rd_ptr;
   assign Data_DO   = r_data;
   assign Fill_DO   = r_fill;
   assign Empty_SO  = (r_fill == '0);
   assign Full_SO   = (r_fill == FILL_MAX);
   assign Ovf_SO    = r_ovf;

endmodule

// File: doc/nyq_rd_ctrl.md
Name: nyq_rd_ctrl

Overview:
Read-side controller for the NYQ sample buffer. It is the companion to the NYQ write counter, which resets to 7 and decrements on each write.
- Mirrors the write pointer sequence: reset to DEPTH-1, decrement on each read.
- Tracks buffer occupancy from the writer's WrEn_SI pulses.
- Drains entries in write order to downstream logic through a registered valid/ready output stage.
- Sits between the NYQ buffer array (asynchronous read port) and the downstream consumer.

Parameters:
DATA_W, 16, width of one buffer entry and of Data_DO
DEPTH, 8, number of buffer entries; power of two; must match the writer counter range (8)
PTR_W, $clog2(DEPTH) = 3, read pointer / buffer address width
FILL_W, PTR_W+1 = 4, occupancy counter width (holds 0..DEPTH)

Ports:
Clk_CI  in  1  clock
Rst_RI  in  1  reset, synchronous, active-high
WrEn_SI  in  1  writer strobe; one entry is committed to the buffer on each clock edge where it is high
RdAddr_DO  out  PTR_W  buffer read address; equals the internal read pointer
RdData_DI  in  DATA_W  buffer read data at RdAddr_DO; combinational, same cycle
Data_DO  out  DATA_W  output data register
Valid_SO  out  1  Data_DO holds an unconsumed entry
Ready_SI  in  1  downstream accepts Data_DO on an edge where Valid_SO && Ready_SI
Fill_DO  out  FILL_W  entries written but not yet loaded into Data_DO
Empty_SO  out  1  Fill_DO == 0
Full_SO  out  1  Fill_DO == DEPTH
Ovf_SO  out  1  overflow indication (see Optional Feature)

Behaviour:
- Reset (Rst_RI high at an edge): RdPtr=DEPTH-1 (7), Fill=0, Valid_SO=0, Data_DO=0, Ovf_SO=0. Reset overrides all other inputs.
- Output-stage FSM:
  - S_EMPTY: Valid_SO=0.
  - S_FULL: Valid_SO=1.
- Load condition: Load = (Fill!=0) && (S_EMPTY || Ready_SI).
- On Load:
  - Data_DO <= RdData_DI; state becomes S_FULL.
  - RdPtr <= RdPtr-1, wrapping 0 -> DEPTH-1.
  - Fill decrements.
- S_FULL, Ready_SI=1, Fill=0: move to S_EMPTY; Data_DO holds its last value.
- S_FULL, Ready_SI=0: Data_DO and Valid_SO held stable. No data change while stalled.
- Fill update per edge:
  - +1 on WrEn_SI, -1 on Load.
  - WrEn_SI and Load together: unchanged.
  - No wrap; Fill stays in 0..DEPTH.
- Overflow: WrEn_SI at Fill==DEPTH without a Load in the same cycle.
  - Fill stays at DEPTH.
  - The writer has overwritten an unread entry. RdPtr is not adjusted.
  - Ovf_SO behaviour is defined under Optional Feature.
- WrEn_SI at Fill==DEPTH together with a Load is legal: Fill stays DEPTH, no overflow.
- Latency: WrEn_SI sampled at edge k with Fill=0 and S_EMPTY gives Valid_SO=1 after edge k+1 (2-edge write-to-valid). Sustained throughput is 1 entry per cycle with Ready_SI held high.
- Address order: 7,6,5,...,0,7,... which matches the writer order.
- Empty_SO and Full_SO are combinational decodes of the Fill register.
- Reset mid-transfer discards the buffered entry and Data_DO contents. The writer counter must be reset in the same cycle.

Optional Feature:
Macro: NYQ_RD_OVF_STICKY_EN
- Defined: Ovf_SO is sticky. It is set on the first overflow and cleared only by Rst_RI.
- Undefined: Ovf_SO is a single-cycle pulse, registered, high during the cycle after each overflow edge.

Decomposition:
- Shared package nyq_pkg holds:
  - NYQ_DEPTH=8 and NYQ_DATA_W=16, used by both writer and reader.
  - FSM state typedef nyq_rd_state_t {S_EMPTY, S_FULL}.
  - Pointer type nyq_ptr_t (3 bits).
- One natural sub-module: nyq_rd_ptr. This is the down-counting wrapping read pointer, the reader-side twin of the write counter, with a synchronous active-high reset to DEPTH-1 and Load as its enable.
- Fill tracking and the output stage stay in the top module.

Test Plan:
- Reset then idle: Rst_RI=1 for 2 cycles, then low -> RdAddr_DO=7, Fill_DO=0, Empty_SO=1, Valid_SO=0, Ovf_SO=0.
- Single write, buffer model word[7]=0xA5A5, WrEn_SI one pulse at edge k, Ready_SI=0:
  - Valid_SO=1 after edge k+1, Data_DO=0xA5A5, RdAddr_DO=6, Fill_DO=0.
  - Data_DO held for 5 stall cycles.
- Streaming: 8 back-to-back writes with Ready_SI=1 -> outputs appear in address order 7..0 one per cycle; RdAddr_DO wraps to 7; Fill_DO never exceeds 2.
- Fill to full: 8 writes with Ready_SI=0 -> first word is loaded, giving Fill_DO=7. One more write gives Fill_DO=8 and Full_SO=1.
- Overflow with Ready_SI=0 at Full_SO=1:
  - Writing once more -> Fill_DO stays 8.
  - Ovf_SO pulses 1 cycle without the macro; stays high until reset with NYQ_RD_OVF_STICKY_EN.
  - A write together with Ready_SI=1 gives no overflow.
- Reset mid-stream: assert Rst_RI while Valid_SO=1, Fill_DO=3 -> next cycle Valid_SO=0, Fill_DO=0, RdAddr_DO=7, Data_DO=0.
